// File: rtl/jls_frame_feeder.sv
// Front-end for jls_encoder: accepts a multi-pixel ready/valid beat stream, issues the
// inew preamble and then serializes pixels one byte per cycle, flagging malformed frames.
module jls_frame_feeder #(
  parameter int unsigned WLEVEL     = 12,
  parameter int unsigned MIN_WIDTH  = 4,
  parameter int unsigned PPB        = 4,
  parameter int unsigned NEW_CYCLES = 368
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WLEVEL-1:0]   cfg_width,
  input  logic [15:0]         cfg_height,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_sof,
  input  logic [8*PPB-1:0]    s_data,
  output logic                inew,
  output logic                ivalid,
  output logic [7:0]          idata,
  output logic [WLEVEL-1:0]   owidth,
  output logic [15:0]         oheight,
  output logic                busy,
  output logic                done,
  output logic                err_short,
  output logic                err_long,
  output logic                err_cfg
);

  localparam int unsigned LW       = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int unsigned CW       = 28;
  localparam int unsigned NCW      = (NEW_CYCLES > 2) ? $clog2(NEW_CYCLES) : 1;
  localparam int unsigned NEW_LAST = (NEW_CYCLES > 1) ? NEW_CYCLES - 2 : 0;

  typedef enum logic [1:0] {S_IDLE, S_NEW, S_PIX} state_e;

  // Registered outputs are decided one cycle ahead, so the internal NEW phase is one
  // cycle shorter than the visible inew run; the SOF cycle itself supplies the first.
  localparam state_e S_FIRST = (NEW_CYCLES > 1) ? S_NEW : S_PIX;

  state_e              state_q, state_d;
  logic [8*PPB-1:0]    hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic [LW-1:0]       lane_q, lane_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       total_q, total_d;
  logic [NCW-1:0]      new_cnt_q, new_cnt_d;
  logic [WLEVEL-1:0]   owidth_q, owidth_d;
  logic [15:0]         oheight_q, oheight_d;
  logic                inew_q, inew_d;
  logic                ivalid_q, ivalid_d;
  logic [7:0]          idata_q, idata_d;
  logic                busy_q, busy_d;
  logic                fin_q, fin_d;
  logic                done_q, done_d;
  logic                err_short_q, err_short_d;
  logic                err_long_q, err_long_d;
  logic                err_cfg_q, err_cfg_d;

  logic                emit, lane_last, frame_last, accept, sof_take, cfg_ok;
  logic [7:0]          lane_byte;

  always_comb begin
    lane_byte = 8'h00;
    for (int k = 0; k < PPB; k++) begin
      if (lane_q == LW'(k)) lane_byte = hold_q[8*k +: 8];
    end
  end

  assign emit       = (state_q == S_PIX) && hold_vld_q;
  assign lane_last  = (lane_q == LW'(PPB - 1));
  assign frame_last = emit && ((cnt_q + CW'(1)) == total_q);
  assign cfg_ok     = (cfg_width >= WLEVEL'(MIN_WIDTH)) && (cfg_height != 16'd0);

  // Ready while idle, or in PIX when the hold drains this cycle without ending the frame.
  assign s_ready = !rst && ((state_q == S_IDLE) ||
                   ((state_q == S_PIX) && (!hold_vld_q || (lane_last && !frame_last))));
  assign accept   = s_valid && s_ready;
  assign sof_take = accept && s_sof;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (sof_take && cfg_ok) state_d = S_FIRST;
      S_NEW:  if (new_cnt_q == NCW'(NEW_LAST)) state_d = S_PIX;
      S_PIX: begin
        if (sof_take)        state_d = cfg_ok ? S_FIRST : S_IDLE;
        else if (frame_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    total_d     = total_q;
    new_cnt_d   = new_cnt_q;
    owidth_d    = owidth_q;
    oheight_d   = oheight_q;
    inew_d      = 1'b0;
    ivalid_d    = 1'b0;
    idata_d     = 8'h00;
    fin_d       = 1'b0;
    done_d      = fin_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    err_cfg_d   = 1'b0;
    busy_d      = (state_q != S_IDLE) || (state_d != S_IDLE);

    if (state_q == S_NEW) begin
      inew_d    = 1'b1;
      new_cnt_d = new_cnt_q + NCW'(1);
    end

    if (emit) begin
      ivalid_d = 1'b1;
      idata_d  = lane_byte;
      cnt_d    = cnt_q + CW'(1);
      lane_d   = lane_last ? LW'(0) : lane_q + LW'(1);
      if (lane_last || frame_last) hold_vld_d = 1'b0;
      if (frame_last) begin
        fin_d  = 1'b1;
        lane_d = LW'(0);
      end
    end

    // Beat acceptance overrides the drain bookkeeping above.
    if (accept) begin
      if (!s_sof) begin
        if (state_q == S_IDLE) begin
          err_long_d = 1'b1;
        end else begin
          hold_d     = s_data;
          hold_vld_d = 1'b1;
          lane_d     = LW'(0);
        end
      end else begin
        if (state_q == S_PIX) err_short_d = 1'b1;
        if (cfg_ok) begin
          owidth_d   = cfg_width;
          oheight_d  = cfg_height;
          total_d    = CW'(cfg_width) * CW'(cfg_height);
          hold_d     = s_data;
          hold_vld_d = 1'b1;
          lane_d     = LW'(0);
          cnt_d      = '0;
          new_cnt_d  = '0;
          inew_d     = 1'b1;
        end else begin
          err_cfg_d  = 1'b1;
          hold_vld_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      lane_q      <= '0;
      cnt_q       <= '0;
      total_q     <= '0;
      new_cnt_q   <= '0;
      owidth_q    <= '0;
      oheight_q   <= '0;
      inew_q      <= 1'b0;
      ivalid_q    <= 1'b0;
      idata_q     <= 8'h00;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
      done_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_cfg_q   <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      total_q     <= total_d;
      new_cnt_q   <= new_cnt_d;
      owidth_q    <= owidth_d;
      oheight_q   <= oheight_d;
      inew_q      <= inew_d;
      ivalid_q    <= ivalid_d;
      idata_q     <= idata_d;
      busy_q      <= busy_d;
      fin_q       <= fin_d;
      done_q      <= done_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      err_cfg_q   <= err_cfg_d;
    end
  end

  assign inew      = inew_q;
  assign ivalid    = ivalid_q;
  assign idata     = idata_q;
  assign owidth    = owidth_q;
  assign oheight   = oheight_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign err_cfg   = err_cfg_q;

endmodule

// File: tb/tb_jls_frame_feeder.sv
// Directed bench for jls_frame_feeder: expected pixels queued as beats are driven,
// popped and compared as ivalid appears; preamble length, latency and pulses checked.
module tb_jls_frame_feeder;
  localparam int unsigned WLEVEL     = 12;
  localparam int unsigned MIN_WIDTH  = 4;
  localparam int unsigned PPB        = 4;
  localparam int unsigned NEW_CYCLES = 368;

  logic              clk = 1'b0;
  logic              rst;
  logic [WLEVEL-1:0] cfg_width;
  logic [15:0]       cfg_height;
  logic              s_valid, s_ready, s_sof;
  logic [8*PPB-1:0]  s_data;
  logic              inew, ivalid, busy, done, err_short, err_long, err_cfg;
  logic [7:0]        idata;
  logic [WLEVEL-1:0] owidth;
  logic [15:0]       oheight;

  always #5 clk = ~clk;

  jls_frame_feeder #(
    .WLEVEL(WLEVEL), .MIN_WIDTH(MIN_WIDTH), .PPB(PPB), .NEW_CYCLES(NEW_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .s_valid(s_valid), .s_ready(s_ready), .s_sof(s_sof), .s_data(s_data),
    .inew(inew), .ivalid(ivalid), .idata(idata), .owidth(owidth), .oheight(oheight),
    .busy(busy), .done(done), .err_short(err_short), .err_long(err_long), .err_cfg(err_cfg)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] sb[$];
  int cyc = 0;
  int iv_cnt = 0, done_cnt = 0, inew_total = 0, inew_run = 0;
  int es = 0, ec = 0, el = 0;
  int first_iv = 0, last_iv = 0, sof_cyc = 0;
  int pushed = 0, frame_total = 0;
  logic prev_inew = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: preamble length, latency, pixel order, done placement and pulse counts.
  always @(negedge clk) begin
    logic [63:0] e;
    if (inew) begin
      inew_run++;
      inew_total++;
    end else if (inew_run != 0) begin
      check("inew_run_len", 64'(inew_run), 64'(NEW_CYCLES));
      inew_run = 0;
    end
    if (done) begin
      done_cnt++;
      check("done_after_last_pixel", 64'(cyc), 64'(last_iv + 1));
    end
    if (ivalid) begin
      if (prev_inew) begin
        first_iv = cyc;
        check("first_pixel_latency", 64'(cyc - sof_cyc), 64'(NEW_CYCLES + 1));
      end
      e = 'x;
      if (sb.size() != 0) e = 64'(sb.pop_front());
      check("pixel", 64'(idata), e);
      iv_cnt++;
      last_iv = cyc;
    end
    if (err_short) es++;
    if (err_cfg)   ec++;
    if (err_long)  el++;
    prev_inew = inew;
  end

  task automatic new_frame(input int w, input int h);
    pushed = 0;
    frame_total = w * h;
  endtask

  task automatic expect_beat(input logic [31:0] d);
    for (int k = 0; k < PPB; k++) begin
      if (pushed < frame_total) begin
        sb.push_back(d[8*k +: 8]);
        pushed++;
      end
    end
  endtask

  task automatic send_beat(input logic sof, input logic [31:0] d,
                           input logic [WLEVEL-1:0] w, input logic [15:0] h);
    int   guard = 0;
    logic taken = 1'b0;
    s_valid = 1'b1; s_sof = sof; s_data = d; cfg_width = w; cfg_height = h;
    while (!taken && guard < 3000) begin
      @(negedge clk);
      if (s_ready) begin
        taken = 1'b1;
        if (sof) sof_cyc = cyc;
      end
      @(posedge clk); #1;
      guard++;
    end
    check("beat_accepted", 64'(taken), 64'(1));
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int g = 0;
    while (done_cnt == n0 && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    check("done_seen", 64'(done_cnt), 64'(n0 + 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int iv0, inew0, g;
    logic [31:0] d;
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; cfg_width = '0; cfg_height = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("s_ready_in_reset", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'({inew, ivalid, idata, owidth, oheight, busy, done,
                                err_short, err_long, err_cfg}), 64'(0));
    check("s_ready_idle", 64'(s_ready), 64'(1));
    @(posedge clk); #1;

    // 4x2 frame, two full beats, back-to-back pixel output.
    new_frame(4, 2);
    expect_beat(32'h03020100); send_beat(1'b1, 32'h03020100, 12'd4, 16'd2);
    expect_beat(32'h07060504); send_beat(1'b0, 32'h07060504, 12'd4, 16'd2);
    wait_done(0);
    check("f1_owidth", 64'(owidth), 64'(4));
    check("f1_oheight", 64'(oheight), 64'(2));
    check("f1_consecutive", 64'(last_iv - first_iv), 64'(7));
    check("f1_pixel_count", 64'(iv_cnt), 64'(8));
    check("f1_no_errors", 64'(es + ec + el), 64'(0));
    idle(2);
    check("f1_busy_cleared", 64'(busy), 64'(0));

    // 5x1 frame: lanes 5..7 of the second beat are discarded; then a clean 4x1 frame.
    new_frame(5, 1);
    expect_beat(32'h13121110); send_beat(1'b1, 32'h13121110, 12'd5, 16'd1);
    expect_beat(32'h17161514); send_beat(1'b0, 32'h17161514, 12'd5, 16'd1);
    wait_done(1);
    check("f2_pixel_count", 64'(iv_cnt), 64'(13));
    new_frame(4, 1);
    expect_beat(32'h23222120); send_beat(1'b1, 32'h23222120, 12'd4, 16'd1);
    wait_done(2);
    check("f3_pixel_count", 64'(iv_cnt), 64'(17));
    check("f3_sb_empty", 64'(sb.size()), 64'(0));

    // 4x4 frame cut short after 8 pixels by a new 4x2 SOF.
    new_frame(4, 4);
    expect_beat(32'h33323130); send_beat(1'b1, 32'h33323130, 12'd4, 16'd4);
    expect_beat(32'h37363534); send_beat(1'b0, 32'h37363534, 12'd4, 16'd4);
    new_frame(4, 2);
    expect_beat(32'h43424140); send_beat(1'b1, 32'h43424140, 12'd4, 16'd2);
    expect_beat(32'h47464544); send_beat(1'b0, 32'h47464544, 12'd4, 16'd2);
    wait_done(3);
    check("short_err_short", 64'(es), 64'(1));
    check("short_owidth_oheight", 64'({owidth, oheight}), 64'({12'd4, 16'd2}));
    check("short_sb_empty", 64'(sb.size()), 64'(0));
    idle(2);

    // Illegal geometry and stray beats outside a frame.
    inew0 = inew_total; iv0 = iv_cnt;
    send_beat(1'b1, 32'hAAAAAAAA, 12'd3, 16'd2);
    send_beat(1'b1, 32'hBBBBBBBB, 12'd4, 16'd0);
    send_beat(1'b0, 32'hCCCCCCCC, 12'd4, 16'd2);
    idle(3);
    check("cfg_err_count", 64'(ec), 64'(2));
    check("long_err_count", 64'(el), 64'(1));
    check("bad_frames_no_inew", 64'(inew_total), 64'(inew0));
    check("bad_frames_no_pixels", 64'(iv_cnt), 64'(iv0));
    check("bad_frames_not_busy", 64'(busy), 64'(0));

    // 64x16 frame with random upstream gaps.
    new_frame(64, 16);
    iv0 = iv_cnt;
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      expect_beat(d);
      send_beat(i == 0, d, 12'd64, 16'd16);
      idle($urandom_range(0, 3));
    end
    wait_done(4);
    idle(10);
    check("big_pixel_count", 64'(iv_cnt - iv0), 64'(1024));
    check("big_done_once", 64'(done_cnt), 64'(5));
    check("big_sb_empty", 64'(sb.size()), 64'(0));

    // Reset while pixels are streaming, then a clean frame.
    new_frame(4, 4);
    expect_beat(32'h53525150); send_beat(1'b1, 32'h53525150, 12'd4, 16'd4);
    iv0 = iv_cnt; g = 0;
    while (iv_cnt == iv0 && g < 1000) begin
      @(posedge clk); #1;
      g++;
    end
    check("pixels_before_reset", 64'(iv_cnt > iv0), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("s_ready_during_reset", 64'(s_ready), 64'(0));
    @(posedge clk); #1;
    check("outputs_after_reset", 64'({inew, ivalid, idata, owidth, oheight, busy, done,
                                      err_short, err_long, err_cfg}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    idle(2);
    new_frame(4, 1);
    expect_beat(32'h63626160); send_beat(1'b1, 32'h63626160, 12'd4, 16'd1);
    wait_done(5);
    idle(3);
    check("post_reset_sb_empty", 64'(sb.size()), 64'(0));
    check("post_reset_error_counts", 64'({es[7:0], ec[7:0], el[7:0]}), 64'({8'd1, 8'd2, 8'd1}));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
